tetris_cmd_gen: RTL and testbench

- Sits directly upstream of the tetris game core, between the four debouncers and the core's control inputs.
- Turns the level-type debounced buttons into single-cycle command events:
  - one event per press,
  - auto-repeat while a button is held,
  - periodic gravity (drop) events.
- Presents the events as one registered command stream with a valid/ready handshake.
- The tetris core consumes cmd/cmd_valid instead of raw button levels.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/tetris_btn_repeat.sv | 98 +++++++++
 rtl/tetris_cmd_gen.sv | 104 ++++++++++
 tb/tb_tetris_cmd_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris command generator: command codes,
// the per-button repeat FSM states and default timings for a 100 MHz clk.
package tetris_pkg;

    localparam logic [1:0] CMD_BTN0 = 2'd0;
    localparam logic [1:0] CMD_BTN1 = 2'd1;
    localparam logic [1:0] CMD_BTN2 = 2'd2;
    localparam logic [1:0] CMD_BTN3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int CLK_HZ             = 100_000_000;
    localparam int DEF_REPEAT_DELAY   = CLK_HZ / 4;   // 250 ms to first repeat
    localparam int DEF_REPEAT_PERIOD  = CLK_HZ / 20;  // 50 ms between repeats
    localparam int DEF_GRAVITY_PERIOD = CLK_HZ / 2;   // 500 ms per drop

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tetris_btn_repeat.sv
// One button's edge detect, IDLE/DELAY/REPEAT auto-repeat FSM and shared
// delay/period counter. Emits a registered one-cycle event per press and
// per auto-repeat. A button held through reset must be released once
// before it can fire again (the armed flag).
module tetris_btn_repeat
    import tetris_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    btn_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          btn_prev;
    logic          armed;
    logic          evt_next;
    logic          press;

    assign press = btn & ~btn_prev & armed;

    // State register plus counter, edge history, arm flag and event pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 1'b0;
            armed    <= 1'b0;
            evt      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            btn_prev <= btn;
            armed    <= armed | ~btn;
            evt      <= evt_next;
        end
    end

    // Next-state logic: release always returns to IDLE
    always_comb begin
        state_next = state;
        if (!btn) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (press) state_next = DELAY;
                DELAY:   if (REPEAT_EN && cnt == DELAY_LAST) state_next = REPEAT;
                REPEAT:  state_next = REPEAT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: event request and counter update for the coming edge
    always_comb begin
        evt_next = 1'b0;
        cnt_next = cnt;
        if (!btn) begin
            cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    evt_next = press;
                end
                DELAY: begin
                    if (REPEAT_EN) begin
                        if (cnt == DELAY_LAST) begin
                            evt_next = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (cnt == PERIOD_LAST) begin
                        evt_next = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: cnt_next = '0;
            endcase
        end
    end

endmodule

// File: rtl/tetris_cmd_gen.sv
// Command generator in front of the tetris core: four auto-repeating
// buttons plus optional gravity, arbitrated into one registered
// valid/ready command stream. Gravity is built only when the macro
// TETRIS_CMD_GRAVITY_EN is defined; otherwise pause is ignored and
// pend_gravity reads 0.
module tetris_cmd_gen
    import tetris_pkg::*;
#(
    parameter int         REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int         REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter logic [3:0] REPEAT_MASK    = 4'b0111,
    parameter int         GRAVITY_PERIOD = DEF_GRAVITY_PERIOD,
    parameter logic [1:0] GRAVITY_CMD    = 2'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       pause,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic       pend_gravity
);

    logic [3:0] evt;
    logic [1:0] btn_code;
    logic       free;
    logic       grav_req;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        tetris_btn_repeat #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_repeat (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .evt   (evt[i])
        );
    end

    assign free = ~cmd_valid | cmd_ready;

`ifdef TETRIS_CMD_GRAVITY_EN
    localparam int GW = $clog2(GRAVITY_PERIOD);
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_PERIOD - 1);

    logic [GW-1:0] grav_cnt;
    logic          pend;
    logic          wrap;
    logic          grav_load;

    assign wrap      = ~pause & (grav_cnt == GRAV_LAST);
    assign grav_load = free & ~(|evt) & pend;

    // Gravity timer; a wrap while one event is pending is simply absorbed
    always_ff @(posedge clk) begin
        if (reset) begin
            grav_cnt <= '0;
            pend     <= 1'b0;
        end else begin
            if (!pause) grav_cnt <= wrap ? '0 : grav_cnt + 1'b1;
            pend <= wrap | (pend & ~grav_load);
        end
    end

    assign grav_req     = pend;
    assign pend_gravity = pend;
`else
    logic unused_gravity;
    assign unused_gravity = pause ^ (GRAVITY_PERIOD > 0);
    assign grav_req       = 1'b0;
    assign pend_gravity   = 1'b0;
`endif

    // Fixed priority: the lowest-index button with an event wins
    always_comb begin
        btn_code = CMD_BTN0;
        if (evt[0])      btn_code = CMD_BTN0;
        else if (evt[1]) btn_code = CMD_BTN1;
        else if (evt[2]) btn_code = CMD_BTN2;
        else if (evt[3]) btn_code = CMD_BTN3;
    end

    // Output register: load when free, hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_BTN0;
        end else if (free) begin
            if (|evt) begin
                cmd_valid <= 1'b1;
                cmd       <= btn_code;
            end else if (grav_req) begin
                cmd_valid <= 1'b1;
                cmd       <= GRAVITY_CMD;
            end else begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tetris_cmd_gen.sv
// Directed bench for tetris_cmd_gen with short timings. Cycle c means the
// c-th rising edge after reset release (first edge is 0); inputs for edge c
// are driven just before it, outputs are sampled 1 time unit after it.
// Gravity checks run when TETRIS_CMD_GRAVITY_EN is defined.
module tb_tetris_cmd_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       pause;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       pend_gravity;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    tetris_cmd_gen #(
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (4),
        .REPEAT_MASK    (4'b0111),
        .GRAVITY_PERIOD (20),
        .GRAVITY_CMD    (2'd1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .pause        (pause),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .pend_gravity (pend_gravity)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic p, input logic r);
        btn       = b;
        pause     = p;
        cmd_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid,
                               input logic [1:0] exp_cmd, input logic exp_pend);
        vectors++;
        assert (cmd_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s cmd_valid @%0d: got %b expected %b", tag, cyc, cmd_valid, exp_valid);
        end
        if (exp_valid) begin
            vectors++;
            assert (cmd === exp_cmd) else begin
                miscompares++;
                $error("[TB] FAIL %s cmd @%0d: got %0d expected %0d", tag, cyc, cmd, exp_cmd);
            end
        end
        vectors++;
        assert (pend_gravity === exp_pend) else begin
            miscompares++;
            $error("[TB] FAIL %s pend_gravity @%0d: got %b expected %b", tag, cyc, pend_gravity, exp_pend);
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        cyc   = -1;
    endtask

    initial begin
        $display("[TB] tetris_cmd_gen directed run");
        restart();

        // Reset values
        vectors++;
        assert (cmd === 2'd0) else begin
            miscompares++;
            $error("[TB] FAIL reset cmd: got %0d expected 0", cmd);
        end
        checkOutput("reset", 1'b0, 2'd0, 1'b0);

        // Tap: btn[2] for three cycles -> one cmd=2 at cycle 6
        for (int c = 0; c <= 20; c++) begin
            applyStimulus((c >= 5 && c <= 7) ? 4'b0100 : 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("tap", c == 6, 2'd2, 1'b0);
        end

        // Hold repeat: btn[0] held 5..40 -> pulses 6,16,20,...,40
        restart();
        for (int c = 0; c <= 50; c++) begin
            applyStimulus((c >= 5 && c <= 40) ? 4'b0001 : 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("hold", (c == 6) || (c >= 16 && c <= 40 && (c - 16) % 4 == 0), 2'd0, 1'b0);
        end

        // Mask: btn[3] does not auto-repeat
        restart();
        for (int c = 0; c <= 55; c++) begin
            applyStimulus((c >= 5 && c <= 44) ? 4'b1000 : 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("mask", c == 6, 2'd3, 1'b0);
        end

        // Priority: btn[1] and btn[2] together -> only cmd=1
        restart();
        for (int c = 0; c <= 15; c++) begin
            applyStimulus((c >= 5 && c <= 7) ? 4'b0110 : 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("prio", c == 6, 2'd1, 1'b0);
        end

        // Back-to-back: event during acceptance loads immediately
        restart();
        for (int c = 0; c <= 10; c++) begin
            applyStimulus((c == 3) ? 4'b0100 : ((c == 4) ? 4'b0001 : 4'b0000), 1'b1, 1'b1);
            tick();
            checkOutput("b2b", (c == 4) || (c == 5), (c == 4) ? 2'd2 : 2'd0, 1'b0);
        end

        // Stall: cmd=1 held while not ready, btn[0] press during stall dropped
        restart();
        for (int c = 0; c <= 15; c++) begin
            applyStimulus((c == 3 || c == 4) ? 4'b0010 : ((c == 8 || c == 9) ? 4'b0001 : 4'b0000),
                          1'b1, c >= 12);
            tick();
            checkOutput("stall", c >= 4 && c <= 11, 2'd1, 1'b0);
        end

        // Reset mid-operation drops the held command; held button stays silent
        restart();
        for (int c = 0; c <= 40; c++) begin
            reset = (c == 12);
            applyStimulus(((c >= 5 && c <= 30) || (c >= 33 && c <= 35)) ? 4'b0001 : 4'b0000,
                          1'b1, c >= 13);
            tick();
            checkOutput("midreset", (c >= 6 && c <= 11) || (c == 34), 2'd0, 1'b0);
        end
        reset = 1'b0;

`ifdef TETRIS_CMD_GRAVITY_EN
        // Gravity with stall: second wrap absorbed, back-to-back reissue
        restart();
        for (int c = 0; c <= 62; c++) begin
            applyStimulus(4'b0000, 1'b0, (c < 15) || (c >= 46));
            tick();
            checkOutput("gravity", (c >= 20 && c <= 46) || (c == 60), 2'd1,
                        (c == 19) || (c >= 39 && c <= 45) || (c == 59));
        end
`else
        // Without gravity, pause=0 produces nothing
        restart();
        for (int c = 0; c <= 49; c++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1);
            tick();
            checkOutput("nogravity", 1'b0, 2'd0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
